kuz_l_transform: RTL and testbench

Iterative Kuznyechik linear layer. It computes L = R^16 (encrypt) or L^-1 = (R^-1)^16 (decrypt) on one 128-bit block. UNROLL R-steps are evaluated per clock, and the block uses valid/ready handshakes on both sides. It sits between the S-box stage and the key-mix stage of the round datapath, and replaces the single-direction, load/ready-pulse linear stage.

---
 rtl/kuz_pkg.sv | 34 +++
 rtl/kuz_l_transform_r_step.sv | 31 +++
 rtl/kuz_l_transform.sv | 110 +++++++++++
 tb/tb_kuz_l_transform.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/kuz_pkg.sv
// Shared types, constants and GF(2^8) helper for the Kuznyechik linear layer.
// The field is GF(2^8) reduced by x^8+x^7+x^6+x+1.
package kuz_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam byte_t GF_POLY = 8'hC3;

  // L_COEF[k] multiplies the byte at bits [127-8k -: 8], so L_COEF[0] pairs with a15.
  localparam byte_t L_COEF [0:15] = '{
    8'h94, 8'h20, 8'h85, 8'h10, 8'hC2, 8'hC0, 8'h01, 8'hFB,
    8'h01, 8'hC0, 8'hC2, 8'h10, 8'h85, 8'h20, 8'h94, 8'h01
  };

  function automatic byte_t gf_mul_const(input byte_t a, input byte_t c);
    byte_t acc;
    byte_t x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) acc = acc ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ GF_POLY) : {x[6:0], 1'b0};
    end
    return acc;
  endfunction

endpackage

// File: rtl/kuz_l_transform_r_step.sv
// One combinational R step (INV=0) or R^-1 step (INV=1).
// The inverse step is the linear function applied to the byte-rotated block.
module kuz_r_step
  import kuz_pkg::*;
#(
  parameter bit INV = 1'b0
) (
  input  logic [127:0] i_blk,
  output logic [127:0] o_blk
);

  block_t w_vec;
  byte_t  w_prod [16];
  byte_t  w_lin;

  assign w_vec = INV ? {i_blk[119:0], i_blk[127:120]} : i_blk;

  for (genvar k = 0; k < 16; k++) begin : g_mul
    assign w_prod[k] = gf_mul_const(w_vec[127-8*k -: 8], L_COEF[k]);
  end

  always_comb begin
    w_lin = '0;
    for (int k = 0; k < 16; k++) begin
      w_lin = w_lin ^ w_prod[k];
    end
  end

  assign o_blk = INV ? {w_vec[127:8], w_lin} : {w_lin, w_vec[127:8]};

endmodule

// File: rtl/kuz_l_transform.sv
// Iterative Kuznyechik L / L^-1 layer: UNROLL chained R steps per clock,
// valid/ready on both sides, DONE may hand straight over to a new block.
module kuz_l_transform
  import kuz_pkg::*;
#(
  parameter int W      = 128,
  parameter int UNROLL = 1,
  parameter bit INV_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);

  localparam int         STEPS    = 16 / UNROLL;
  localparam logic [3:0] CNT_INIT = 4'(STEPS - 1);

  if (W != 128) begin : g_bad_w
    $error("kuz_l_transform: W must be 128");
  end
  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8 && UNROLL != 16) begin : g_bad_unroll
    $error("kuz_l_transform: UNROLL must be 1, 2, 4, 8 or 16");
  end

  state_t     r_st;
  state_t     w_st_nxt;
  block_t     r_state;
  logic       r_mode;
  logic [3:0] r_cnt;
  logic       w_accept;
  block_t     w_fwd [0:UNROLL];
  block_t     w_inv_last;
  block_t     w_step;

  assign w_fwd[0] = r_state;
  for (genvar k = 0; k < UNROLL; k++) begin : g_fwd
    kuz_r_step #(.INV(1'b0)) u_step (.i_blk(w_fwd[k]), .o_blk(w_fwd[k+1]));
  end

  if (INV_EN) begin : g_inv
    block_t w_inv [0:UNROLL];
    assign w_inv[0] = r_state;
    for (genvar k = 0; k < UNROLL; k++) begin : g_chain
      kuz_r_step #(.INV(1'b1)) u_step (.i_blk(w_inv[k]), .o_blk(w_inv[k+1]));
    end
    assign w_inv_last = w_inv[UNROLL];
  end else begin : g_no_inv
    // r_mode is forced to 0 on accept, so this leg is never selected.
    assign w_inv_last = w_fwd[UNROLL];
  end

  assign w_step   = r_mode ? w_inv_last : w_fwd[UNROLL];
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst) r_st <= ST_IDLE;
    else      r_st <= w_st_nxt;
  end

  always_comb begin
    w_st_nxt = r_st;
    unique case (r_st)
      ST_IDLE: if (in_valid)      w_st_nxt = ST_BUSY;
      ST_BUSY: if (r_cnt == 4'd0) w_st_nxt = ST_DONE;
      ST_DONE: if (out_ready)     w_st_nxt = in_valid ? ST_BUSY : ST_IDLE;
      default:                    w_st_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (r_st)
      ST_IDLE: in_ready = 1'b1;
      ST_BUSY: busy     = 1'b1;
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Block state is cleared on reset so out_data is defined (zero) right away.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= '0;
      r_mode  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_state <= in_data;
      r_mode  <= in_inv & INV_EN;
      r_cnt   <= CNT_INIT;
    end else if (r_st == ST_BUSY) begin
      r_state <= w_step;
      if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
    end
  end

  assign out_data = r_state;

endmodule

// File: tb/tb_kuz_l_transform.sv
// Directed-vector bench for kuz_l_transform: three unroll factors plus a
// forward-only build share one stimulus bus; a bare R-step pair is probed too.
module tb_kuz_l_transform;

  localparam logic [127:0] V_A  = 128'h64a59400000000000000000000000000;
  localparam logic [127:0] V_B  = 128'hd456584dd0e3e84cc3166e4b7fa2890d;
  localparam logic [127:0] V_C  = 128'h79d26221b87b584cd42fbc4ffea5de9a;
  localparam logic [127:0] V_D  = 128'h0e93691a0cfc60408b7b68f66b513c13;
  localparam logic [127:0] V_E  = 128'he6a8094fee0aa204fd97bcb0b44b8580;
  localparam int EXP_LAT [4] = '{16, 4, 1, 1};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_inv;
  logic [127:0] in_data;
  logic         out_ready;
  logic         rdy [4];
  logic         ov  [4];
  logic         bsy [4];
  logic [127:0] od  [4];
  logic [127:0] pr_in;
  logic [127:0] pr_fwd;
  logic [127:0] pr_back;
  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  kuz_l_transform #(.W(128), .UNROLL(1), .INV_EN(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_inv(in_inv),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .busy(bsy[0]));
  kuz_l_transform #(.W(128), .UNROLL(4), .INV_EN(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_inv(in_inv),
    .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .busy(bsy[1]));
  kuz_l_transform #(.W(128), .UNROLL(16), .INV_EN(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_inv(in_inv),
    .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .busy(bsy[2]));
  kuz_l_transform #(.W(128), .UNROLL(16), .INV_EN(1'b0)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]), .in_inv(in_inv),
    .in_data(in_data), .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]), .busy(bsy[3]));

  kuz_r_step #(.INV(1'b0)) u_rf (.i_blk(pr_in),  .o_blk(pr_fwd));
  kuz_r_step #(.INV(1'b1)) u_ri (.i_blk(pr_fwd), .o_blk(pr_back));

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b0; pr_in = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (ov[i] !== 1'b0) $display("FAIL reset_out_valid dut%0d got %b want 0", i, ov[i]); else n_pass++;
      n_chk++; if (bsy[i] !== 1'b0) $display("FAIL reset_busy dut%0d got %b want 0", i, bsy[i]); else n_pass++;
      n_chk++; if (rdy[i] !== 1'b1) $display("FAIL reset_in_ready dut%0d got %b want 1", i, rdy[i]); else n_pass++;
      n_chk++; if (od[i] !== 128'h0) $display("FAIL reset_out_data dut%0d got %h want 0", i, od[i]); else n_pass++;
    end
    rst = 1'b1;
  endtask

  task automatic test_r_step();
    pr_in = 128'h00000000000000000000000000000100;
    #1;
    n_chk++;
    if (pr_fwd !== 128'h94000000000000000000000000000001)
      $display("FAIL r_step_fwd got %h want 94000000000000000000000000000001", pr_fwd);
    else n_pass++;
    n_chk++;
    if (pr_back !== 128'h00000000000000000000000000000100)
      $display("FAIL r_step_inv got %h want 00000000000000000000000000000100", pr_back);
    else n_pass++;
  endtask

  // Single transaction on all four instances; in_inv/in_data are scrambled after accept.
  task automatic run_block(input logic [127:0] din, input logic inv, input logic [127:0] exp,
                           input logic [127:0] exp_fwd_only, input logic chk_fwd_only, input string name);
    int           lat  [4];
    logic [127:0] got  [4];
    for (int i = 0; i < 4; i++) begin lat[i] = -1; got[i] = '0; end
    in_data = din; in_inv = inv; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_inv = ~inv; in_data = ~din;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
        if (ov[i] && lat[i] < 0) begin lat[i] = c; got[i] = od[i]; end
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (lat[i] != EXP_LAT[i]) $display("FAIL %s_latency dut%0d got %0d want %0d", name, i, lat[i], EXP_LAT[i]);
      else n_pass++;
      if (i < 3) begin
        n_chk++;
        if (got[i] !== exp) $display("FAIL %s_data dut%0d got %h want %h", name, i, got[i], exp);
        else n_pass++;
      end else if (chk_fwd_only) begin
        n_chk++;
        if (got[i] !== exp_fwd_only) $display("FAIL %s_data dut%0d got %h want %h", name, i, got[i], exp_fwd_only);
        else n_pass++;
      end
    end
  endtask

  task automatic test_forward();
    run_block(V_A, 1'b0, V_B, V_B, 1'b1, "fwd_a");
  endtask

  task automatic test_chain();
    run_block(V_B, 1'b0, V_C, V_C, 1'b1, "chain_b");
    run_block(V_C, 1'b0, V_D, V_D, 1'b1, "chain_c");
    run_block(V_D, 1'b0, V_E, V_E, 1'b1, "chain_d");
  endtask

  task automatic test_inverse();
    run_block(V_E, 1'b1, V_D, '0, 1'b0, "inv_e");
    // The forward-only build must ignore in_inv and produce L(V_B).
    run_block(V_B, 1'b1, V_A, V_C, 1'b1, "inv_b");
  endtask

  task automatic test_backpressure();
    int c;
    in_data = V_A; in_inv = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    c = 0;
    while (!ov[0] && c < 20) begin
      @(posedge clk);
      #1;
      c++;
    end
    n_chk++; if (c != 16) $display("FAIL bp_latency got %0d want 16", c); else n_pass++;
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0]; in_inv = k[1]; in_data = {4{32'hdeadbeef ^ k}};
      #1;
      n_chk++; if (rdy[0] !== 1'b0) $display("FAIL bp_in_ready cycle%0d got %b want 0", k, rdy[0]); else n_pass++;
      @(posedge clk);
      #1;
      n_chk++; if (ov[0] !== 1'b1) $display("FAIL bp_out_valid cycle%0d got %b want 1", k, ov[0]); else n_pass++;
      n_chk++; if (od[0] !== V_B) $display("FAIL bp_out_data cycle%0d got %h want %h", k, od[0], V_B); else n_pass++;
      n_chk++; if (od[1] !== V_B) $display("FAIL bp_out_data_u4 cycle%0d got %h want %h", k, od[1], V_B); else n_pass++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    n_chk++; if (rdy[0] !== 1'b1) $display("FAIL bp_release_in_ready got %b want 1", rdy[0]); else n_pass++;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (ov[i] !== 1'b0) $display("FAIL bp_consumed dut%0d got %b want 0", i, ov[i]); else n_pass++;
      n_chk++; if (bsy[i] !== 1'b0) $display("FAIL bp_no_capture dut%0d got %b want 0", i, bsy[i]); else n_pass++;
    end
    repeat (17) @(posedge clk);
    #1;
    n_chk++; if (ov[0] !== 1'b0) $display("FAIL bp_single_result got %b want 0", ov[0]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [127:0] vin  [4];
    logic [127:0] vexp [4];
    int  idx, nout, last_c;
    logic acc;
    vin  = '{V_A, V_B, V_C, V_D};
    vexp = '{V_B, V_C, V_D, V_E};
    idx = 0; nout = 0; last_c = -1;
    out_ready = 1'b1; in_inv = 1'b0; in_valid = 1'b1; in_data = vin[0];
    for (int c = 0; c < 120 && nout < 4; c++) begin
      @(negedge clk);
      acc = in_valid && rdy[0];
      if (ov[0] && in_valid) begin
        n_chk++; if (acc !== 1'b1) $display("FAIL b2b_bypass_accept cycle%0d got %b want 1", c, acc); else n_pass++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 4) in_data = vin[idx];
        else in_valid = 1'b0;
      end
      if (ov[0]) begin
        n_chk++;
        if (od[0] !== vexp[nout]) $display("FAIL b2b_data%0d got %h want %h", nout, od[0], vexp[nout]);
        else n_pass++;
        // Accept-to-accept period is one BUSY run plus the shared DONE cycle.
        if (nout > 0) begin
          n_chk++;
          if (c - last_c != 17) $display("FAIL b2b_spacing%0d got %0d want 17", nout, c - last_c);
          else n_pass++;
        end
        last_c = c;
        nout++;
      end
    end
    n_chk++; if (nout != 4) $display("FAIL b2b_count got %0d want 4", nout); else n_pass++;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    in_data = V_A; in_inv = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_chk++; if (bsy[0] !== 1'b1) $display("FAIL rst_mid_busy_before got %b want 1", bsy[0]); else n_pass++;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (ov[i] !== 1'b0) $display("FAIL rst_mid_out_valid dut%0d got %b want 0", i, ov[i]); else n_pass++;
      n_chk++; if (bsy[i] !== 1'b0) $display("FAIL rst_mid_busy dut%0d got %b want 0", i, bsy[i]); else n_pass++;
      n_chk++; if (od[i] !== 128'h0) $display("FAIL rst_mid_out_data dut%0d got %h want 0", i, od[i]); else n_pass++;
      n_chk++; if (rdy[i] !== 1'b1) $display("FAIL rst_mid_in_ready dut%0d got %b want 1", i, rdy[i]); else n_pass++;
    end
    rst = 1'b1;
    repeat (17) @(posedge clk);
    #1;
    n_chk++; if (ov[0] !== 1'b0) $display("FAIL rst_mid_no_partial got %b want 0", ov[0]); else n_pass++;
    run_block(V_B, 1'b0, V_C, V_C, 1'b1, "after_rst");
  endtask

  initial begin
    test_reset();
    test_r_step();
    test_forward();
    test_chain();
    test_inverse();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
